bilstm_sequence_controller: RTL and testbench

Top-level time-step sequencer for one LSTM cell instance in the BiLSTM. It launches the cell once per time step, forward then backward over the sequence, and drives `seq_idx_control`. It turns the cell's `hidden_state_valid`/`cell_state_valid` strobes into addressed write strobes for the hidden-output and cell-state buffers. After the last backward step it raises `bilstm_done`.

---
 rtl/bilstm_pkg.sv | 31 +++
 rtl/bilstm_sequence_controller_if.sv | 53 +++++
 rtl/bilstm_sequence_controller_element_write_counter.sv | 63 ++++++
 rtl/bilstm_sequence_controller.sv | 180 ++++++++++++++++++
 tb/tb_bilstm_sequence_controller.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bilstm_pkg.sv
// Shared types and sizing helpers for the BiLSTM time-step sequencer.
package bilstm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_SEQ_LEN       = 10;
    localparam int DEF_SEQ_IDX_WIDTH = 4;
    localparam int DEF_HIDDEN_SIZE   = 64;
    localparam int DEF_HID_CNT_WIDTH = 7;

    // hidden buffer address = {direction, seq_idx, element}
    function automatic int hid_addr_width(input int seq_idx_w, input int hid_cnt_w);
        return 1 + seq_idx_w + hid_cnt_w;
    endfunction

    // cell buffer address = {direction, element}
    function automatic int cell_addr_width(input int hid_cnt_w);
        return 1 + hid_cnt_w;
    endfunction

    localparam int DEF_HID_ADDR_WIDTH  = hid_addr_width(DEF_SEQ_IDX_WIDTH, DEF_HID_CNT_WIDTH);
    localparam int DEF_CELL_ADDR_WIDTH = cell_addr_width(DEF_HID_CNT_WIDTH);

endpackage

// File: rtl/bilstm_sequence_controller_if.sv
// Handshake bundle between the sequencer, the LSTM cell and the state buffers.
interface bilstm_sequence_controller_if
    import bilstm_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SEQ_IDX_WIDTH = DEF_SEQ_IDX_WIDTH,
    parameter int HID_CNT_WIDTH = DEF_HID_CNT_WIDTH
);
    localparam int HID_ADDR_W  = hid_addr_width(SEQ_IDX_WIDTH, HID_CNT_WIDTH);
    localparam int CELL_ADDR_W = cell_addr_width(HID_CNT_WIDTH);

    logic                     start;
    logic                     cell_done;
    logic                     hidden_state_valid;
    logic [DATA_WIDTH-1:0]    hidden_state;
    logic                     cell_state_valid;
    logic [DATA_WIDTH-1:0]    current_cell_state;

    logic                     start_cell;
    logic [SEQ_IDX_WIDTH-1:0] seq_idx_control;
    logic                     direction;
    logic                     prev_state_zero;
    logic                     hidden_wr_en;
    logic [HID_ADDR_W-1:0]    hidden_wr_addr;
    logic [DATA_WIDTH-1:0]    hidden_wr_data;
    logic                     cell_wr_en;
    logic [CELL_ADDR_W-1:0]   cell_wr_addr;
    logic [DATA_WIDTH-1:0]    cell_wr_data;
    logic                     busy;
    logic                     bilstm_done;
    logic                     seq_error;

    // sequencer side
    modport master (
        input  start, cell_done, hidden_state_valid, hidden_state,
               cell_state_valid, current_cell_state,
        output start_cell, seq_idx_control, direction, prev_state_zero,
               hidden_wr_en, hidden_wr_addr, hidden_wr_data,
               cell_wr_en, cell_wr_addr, cell_wr_data,
               busy, bilstm_done, seq_error
    );

    // cell / buffer / host side
    modport slave (
        output start, cell_done, hidden_state_valid, hidden_state,
               cell_state_valid, current_cell_state,
        input  start_cell, seq_idx_control, direction, prev_state_zero,
               hidden_wr_en, hidden_wr_addr, hidden_wr_data,
               cell_wr_en, cell_wr_addr, cell_wr_data,
               busy, bilstm_done, seq_error
    );

endinterface

// File: rtl/bilstm_sequence_controller_element_write_counter.sv
// Turns an element strobe into an addressed, registered buffer write and
// counts elements per step; saturates at HIDDEN_SIZE.
module element_write_counter #(
    parameter int DATA_WIDTH   = 16,
    parameter int PREFIX_WIDTH = 5,
    parameter int CNT_WIDTH    = 7,
    parameter int HIDDEN_SIZE  = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              enable_i,
    input  logic                              strobe_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic [PREFIX_WIDTH-1:0]           prefix_i,
    output logic                              wr_en_o,
    output logic [PREFIX_WIDTH+CNT_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]             wr_data_o,
    output logic [CNT_WIDTH-1:0]              count_o,
    output logic                              overflow_o
);
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(HIDDEN_SIZE);

    logic                              wr_en_q;
    logic [PREFIX_WIDTH+CNT_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]             data_q;
    logic [CNT_WIDTH-1:0]              count_q;
    logic                              ovf_q;
    logic                              accept;

    // a strobe is written only while enabled, not being cleared, and not full
    assign accept = strobe_i && enable_i && !clear_i && (count_q != FULL);

    // write register, element count and dropped-strobe pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_en_q <= accept;
            ovf_q   <= strobe_i && !accept;
            if (accept) begin
                addr_q <= {prefix_i, count_q};
                data_q <= data_i;
            end
            if (clear_i) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/bilstm_sequence_controller.sv
// Time-step sequencer for one LSTM cell: forward then backward over the
// sequence, with addressed write strobes for the hidden and cell buffers.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LAUNCH | start_cell pulse, element counters cleared
// RUN    | cell computing; strobes become buffer writes
// STEP   | counts checked, advance step/direction
// DONE   | pass complete, bilstm_done held until next start
module bilstm_sequence_controller
    import bilstm_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SEQ_LEN       = DEF_SEQ_LEN,
    parameter int SEQ_IDX_WIDTH = DEF_SEQ_IDX_WIDTH,
    parameter int HIDDEN_SIZE   = DEF_HIDDEN_SIZE,
    parameter int HID_CNT_WIDTH = DEF_HID_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    bilstm_sequence_controller_if.master bus
);
    localparam logic [SEQ_IDX_WIDTH-1:0] LAST_STEP = SEQ_IDX_WIDTH'(SEQ_LEN - 1);
    localparam logic [HID_CNT_WIDTH-1:0] FULL      = HID_CNT_WIDTH'(HIDDEN_SIZE);

    state_t                   state_q;
    logic [SEQ_IDX_WIDTH-1:0] step_q;
    logic                     dir_q;
    logic [SEQ_IDX_WIDTH-1:0] seq_idx_q;
    logic                     prev_zero_q;
    logic                     start_cell_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     error_q;

    logic [SEQ_IDX_WIDTH-1:0] step_d;
    logic                     dir_d;
    logic [SEQ_IDX_WIDTH-1:0] seq_idx_d;
    logic                     last_step;

    logic                     cnt_clear;
    logic                     cnt_enable;
    logic [HID_CNT_WIDTH-1:0] hid_count;
    logic [HID_CNT_WIDTH-1:0] cell_count;
    logic                     hid_ovf;
    logic                     cell_ovf;

    assign cnt_clear  = (state_q == ST_LAUNCH);
    assign cnt_enable = (state_q == ST_RUN);

    element_write_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PREFIX_WIDTH(1 + SEQ_IDX_WIDTH),
        .CNT_WIDTH   (HID_CNT_WIDTH),
        .HIDDEN_SIZE (HIDDEN_SIZE)
    ) u_hidden_cnt (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .strobe_i  (bus.hidden_state_valid),
        .data_i    (bus.hidden_state),
        .prefix_i  ({dir_q, seq_idx_q}),
        .wr_en_o   (bus.hidden_wr_en),
        .wr_addr_o (bus.hidden_wr_addr),
        .wr_data_o (bus.hidden_wr_data),
        .count_o   (hid_count),
        .overflow_o(hid_ovf)
    );

    element_write_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PREFIX_WIDTH(1),
        .CNT_WIDTH   (HID_CNT_WIDTH),
        .HIDDEN_SIZE (HIDDEN_SIZE)
    ) u_cell_cnt (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .strobe_i  (bus.cell_state_valid),
        .data_i    (bus.current_cell_state),
        .prefix_i  (dir_q),
        .wr_en_o   (bus.cell_wr_en),
        .wr_addr_o (bus.cell_wr_addr),
        .wr_data_o (bus.cell_wr_data),
        .count_o   (cell_count),
        .overflow_o(cell_ovf)
    );

    // next step/direction and its sequence index (backward runs high to low)
    always_comb begin
        step_d    = '0;
        dir_d     = dir_q;
        last_step = 1'b0;
        if (step_q != LAST_STEP) begin
            step_d = step_q + 1'b1;
        end else if (!dir_q) begin
            dir_d = 1'b1;
        end else begin
            last_step = 1'b1;
        end
        seq_idx_d = dir_d ? (LAST_STEP - step_d) : step_d;
    end

    // sequencing FSM with registered outputs and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            dir_q        <= 1'b0;
            seq_idx_q    <= '0;
            prev_zero_q  <= 1'b0;
            start_cell_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            start_cell_q <= 1'b0;
            if (hid_ovf || cell_ovf || (bus.cell_done && state_q != ST_RUN)) begin
                error_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q      <= ST_LAUNCH;
                        step_q       <= '0;
                        dir_q        <= 1'b0;
                        seq_idx_q    <= '0;
                        prev_zero_q  <= 1'b1;
                        start_cell_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        // clearing wins over any error raised this cycle
                        error_q      <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.cell_done) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    // counters already include strobes from the cell_done cycle
                    if (hid_count != FULL || cell_count != FULL) begin
                        error_q <= 1'b1;
                    end
                    if (last_step) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q      <= ST_LAUNCH;
                        step_q       <= step_d;
                        dir_q        <= dir_d;
                        seq_idx_q    <= seq_idx_d;
                        prev_zero_q  <= (step_d == '0);
                        start_cell_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_cell      = start_cell_q;
    assign bus.seq_idx_control = seq_idx_q;
    assign bus.direction       = dir_q;
    assign bus.prev_state_zero = prev_zero_q;
    assign bus.busy            = busy_q;
    assign bus.bilstm_done     = done_q;
    assign bus.seq_error       = error_q;

endmodule

// File: tb/tb_bilstm_sequence_controller.sv
// Randomised bench with an idealised LSTM cell and a transaction-level
// expectation model for launches and buffer writes.
module tb_bilstm_sequence_controller;
    localparam int DW   = 16;
    localparam int SL   = 3;
    localparam int SIW  = 2;
    localparam int HS   = 4;
    localparam int HCW  = 3;
    localparam int HAW  = 1 + SIW + HCW;
    localparam int CAW  = 1 + HCW;

    typedef struct {
        int            cyc;
        logic [HAW-1:0] addr;
        logic [DW-1:0]  data;
    } hw_t;

    typedef struct {
        int            cyc;
        logic [CAW-1:0] addr;
        logic [DW-1:0]  data;
    } cw_t;

    typedef struct {
        int             cyc;
        logic [SIW-1:0] idx;
        logic           dir;
        logic           psz;
    } ln_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    hw_t exp_h[$];
    cw_t exp_c[$];
    ln_t exp_l[$];
    int  obs_idx[$];
    int  obs_dir[$];
    hw_t mh;
    cw_t mc;
    ln_t ml;

    bilstm_sequence_controller_if #(
        .DATA_WIDTH(DW), .SEQ_IDX_WIDTH(SIW), .HID_CNT_WIDTH(HCW)
    ) bus ();

    bilstm_sequence_controller #(
        .DATA_WIDTH(DW), .SEQ_LEN(SL), .SEQ_IDX_WIDTH(SIW),
        .HIDDEN_SIZE(HS), .HID_CNT_WIDTH(HCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // step k of a pass (0..2*SL-1) -> index, direction, first-step flag
    function automatic void step_info(input int k, output logic [SIW-1:0] idx,
                                      output logic dir, output logic psz);
        int s;
        s   = k % SL;
        dir = (k >= SL);
        idx = SIW'(dir ? (SL - 1 - s) : s);
        psz = (s == 0);
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({bus.start_cell, bus.seq_idx_control, bus.direction, bus.prev_state_zero,
                    bus.hidden_wr_en, bus.hidden_wr_addr, bus.hidden_wr_data,
                    bus.cell_wr_en, bus.cell_wr_addr, bus.cell_wr_data,
                    bus.busy, bus.bilstm_done, bus.seq_error});
    endfunction

    // per-cycle compare of launches and buffer writes against the model queues
    always @(negedge clk) begin
        if (rst) begin
            if (exp_h.size() > 0 && exp_h[0].cyc == cyc) begin
                mh = exp_h.pop_front();
                chk(bus.hidden_wr_en == 1'b1, "hid_wr_en", 64'(bus.hidden_wr_en), 64'd1);
                chk(bus.hidden_wr_addr == mh.addr, "hid_wr_addr", 64'(bus.hidden_wr_addr), 64'(mh.addr));
                chk(bus.hidden_wr_data == mh.data, "hid_wr_data", 64'(bus.hidden_wr_data), 64'(mh.data));
            end else begin
                chk(bus.hidden_wr_en == 1'b0, "hid_wr_spurious", 64'(bus.hidden_wr_en), 64'd0);
            end
            if (exp_c.size() > 0 && exp_c[0].cyc == cyc) begin
                mc = exp_c.pop_front();
                chk(bus.cell_wr_en == 1'b1, "cell_wr_en", 64'(bus.cell_wr_en), 64'd1);
                chk(bus.cell_wr_addr == mc.addr, "cell_wr_addr", 64'(bus.cell_wr_addr), 64'(mc.addr));
                chk(bus.cell_wr_data == mc.data, "cell_wr_data", 64'(bus.cell_wr_data), 64'(mc.data));
            end else begin
                chk(bus.cell_wr_en == 1'b0, "cell_wr_spurious", 64'(bus.cell_wr_en), 64'd0);
            end
            if (exp_l.size() > 0 && exp_l[0].cyc == cyc) begin
                ml = exp_l.pop_front();
                chk(bus.start_cell == 1'b1, "launch_pulse", 64'(bus.start_cell), 64'd1);
                chk(bus.seq_idx_control == ml.idx, "launch_idx", 64'(bus.seq_idx_control), 64'(ml.idx));
                chk(bus.direction == ml.dir, "launch_dir", 64'(bus.direction), 64'(ml.dir));
                chk(bus.prev_state_zero == ml.psz, "launch_psz", 64'(bus.prev_state_zero), 64'(ml.psz));
                chk(bus.busy == 1'b1, "launch_busy", 64'(bus.busy), 64'd1);
            end else begin
                chk(bus.start_cell == 1'b0, "launch_spurious", 64'(bus.start_cell), 64'd0);
            end
            if (bus.start_cell) begin
                obs_idx.push_back(int'(bus.seq_idx_control));
                obs_dir.push_back(int'(bus.direction));
            end
        end
    end

    task automatic idle_inputs();
        bus.start              = 1'b0;
        bus.cell_done          = 1'b0;
        bus.hidden_state_valid = 1'b0;
        bus.hidden_state       = '0;
        bus.cell_state_valid   = 1'b0;
        bus.current_cell_state = '0;
    endtask

    // mode 0 nominal, 1 reset in forward step 1, 2 short step, 3 overflow step
    task automatic run_pass(input int mode);
        int             hs, cs, hc, cc, hplan, cplan, guard, c_done, lit_i;
        bit             merr, done_same, hv, cv, fin, first, lit_hv;
        logic [SIW-1:0] idx, nidx;
        logic           dir, psz, ndir, npsz;
        logic [DW-1:0]  d;
        int             lit_idx[6] = '{0, 1, 2, 2, 1, 0};
        int             lit_dir[6] = '{0, 0, 0, 1, 1, 1};

        merr = 1'b0;
        obs_idx.delete();
        obs_dir.delete();
        c_done = 0;

        @(negedge clk);
        bus.start = 1'b1;
        exp_l.push_back('{cyc + 1, SIW'(0), 1'b0, 1'b1});
        @(negedge clk);
        bus.start = 1'b0;
        chk(bus.seq_error == 1'b0, "err_clear_on_start", 64'(bus.seq_error), 64'd0);
        chk(bus.bilstm_done == 1'b0, "done_clear_on_start", 64'(bus.bilstm_done), 64'd0);

        for (int k = 0; k < 2 * SL; k++) begin
            step_info(k, idx, dir, psz);
            guard = 0;
            while (!bus.start_cell && guard < 16) begin
                @(negedge clk);
                guard++;
            end
            chk(guard < 16, "launch_wait", 64'(guard), 64'd16);
            if (guard >= 16) return;
            @(negedge clk);

            chk(bus.seq_idx_control == idx, "run_idx", 64'(bus.seq_idx_control), 64'(idx));
            chk(bus.prev_state_zero == psz, "run_psz", 64'(bus.prev_state_zero), 64'(psz));
            chk(bus.busy == 1'b1, "run_busy", 64'(bus.busy), 64'd1);

            hplan = HS;
            cplan = HS;
            if (mode == 2 && k == 2) hplan = HS - 1;
            if (mode == 3 && k == 3) hplan = HS + 1;
            done_same = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            hs = 0; cs = 0; hc = 0; cc = 0;
            fin = 1'b0;
            first = 1'b1;
            lit_hv = 1'b0;
            lit_i = 0;
            guard = 0;

            while (!fin && guard < 64) begin
                guard++;
                if (mode == 1 && k == 1 && hs == 2) begin
                    idle_inputs();
                    chk(bus.busy == 1'b1, "busy_before_reset", 64'(bus.busy), 64'd1);
                    #2 rst = 1'b0;
                    #1 chk(all_outputs() == 64'd0, "outputs_in_reset", all_outputs(), 64'd0);
                    exp_h.delete();
                    exp_c.delete();
                    exp_l.delete();
                    repeat (2) @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                bus.start = (mode == 0 && k == 2 && first);
                first = 1'b0;
                hv = (hs < hplan) && ((mode == 0 && k == 4) || $urandom_range(0, 2) != 0);
                cv = (cs < cplan) && ($urandom_range(0, 2) != 0);
                bus.hidden_state_valid = hv;
                bus.cell_state_valid   = cv;
                bus.cell_done          = 1'b0;
                lit_hv = hv && (mode == 0 && k == 4);
                lit_i  = hs;
                if (hv) begin
                    d = (mode == 0 && k == 4) ? DW'(16'h0100 + hs) : DW'($urandom);
                    bus.hidden_state = d;
                    if (hc < HS) begin
                        exp_h.push_back('{cyc + 1, {dir, idx, HCW'(hc)}, d});
                        hc++;
                    end else begin
                        merr = 1'b1;
                    end
                    hs++;
                end
                if (cv) begin
                    d = DW'($urandom);
                    bus.current_cell_state = d;
                    if (cc < HS) begin
                        exp_c.push_back('{cyc + 1, {dir, HCW'(cc)}, d});
                        cc++;
                    end else begin
                        merr = 1'b1;
                    end
                    cs++;
                end
                if (hs == hplan && cs == cplan && (done_same || !(hv || cv))) begin
                    bus.cell_done = 1'b1;
                    fin = 1'b1;
                    c_done = cyc;
                    if (hc != HS || cc != HS) merr = 1'b1;
                    if (k < 2 * SL - 1) begin
                        step_info(k + 1, nidx, ndir, npsz);
                        exp_l.push_back('{cyc + 2, nidx, ndir, npsz});
                    end
                end
                @(negedge clk);
                if (lit_hv) begin
                    chk(bus.hidden_wr_addr == HAW'(6'h28 + lit_i), "addr_bwd_step1",
                        64'(bus.hidden_wr_addr), 64'(6'h28 + lit_i));
                    chk(bus.hidden_wr_data == DW'(16'h0100 + lit_i), "data_bwd_step1",
                        64'(bus.hidden_wr_data), 64'(16'h0100 + lit_i));
                end
            end
            idle_inputs();
            chk(fin, "cell_step_budget", 64'(guard), 64'd64);
            if (!fin) return;
        end

        chk(cyc == c_done + 1, "step_after_last_done", 64'(cyc), 64'(c_done + 1));
        chk(bus.bilstm_done == 1'b0, "done_not_early", 64'(bus.bilstm_done), 64'd0);
        chk(bus.busy == 1'b1, "busy_in_last_step", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk(bus.bilstm_done == 1'b1, "done_at_c_plus_2", 64'(bus.bilstm_done), 64'd1);
        chk(bus.busy == 1'b0, "busy_low_at_done", 64'(bus.busy), 64'd0);
        chk(bus.seq_error == merr, "seq_error_final", 64'(bus.seq_error), 64'(merr));
        chk(obs_idx.size() == 2 * SL, "launch_count", 64'(obs_idx.size()), 64'(2 * SL));
        chk(exp_h.size() == 0 && exp_c.size() == 0 && exp_l.size() == 0, "queues_drained",
            64'(exp_h.size() + exp_c.size() + exp_l.size()), 64'd0);
        if (mode == 0 && obs_idx.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk(obs_idx[i] == lit_idx[i], "idx_sequence", 64'(obs_idx[i]), 64'(lit_idx[i]));
                chk(obs_dir[i] == lit_dir[i], "dir_sequence", 64'(obs_dir[i]), 64'(lit_dir[i]));
            end
        end
        if (mode == 2 || mode == 3) begin
            chk(bus.seq_error == 1'b1, "seq_error_set", 64'(bus.seq_error), 64'd1);
        end
        repeat (3) @(negedge clk);
        chk(bus.bilstm_done == 1'b1, "done_held", 64'(bus.bilstm_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(all_outputs() == 64'd0, "reset_state", all_outputs(), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk(all_outputs() == 64'd0, "idle_after_release", all_outputs(), 64'd0);

        run_pass(0);
        run_pass(1);
        run_pass(2);
        run_pass(3);
        run_pass(0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
